// File: rtl/tych_pkt_loopback.sv
// Store-and-forward packet loopback: buffers MAC RX packets, drops bad or
// oversized ones, and replays committed packets on MAC TX with backpressure.
module tych_pkt_loopback #(
  parameter int DATA_W   = 512,
  parameter int DEPTH    = 64,
  parameter int SKIP_CRC = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mac_0_rx_data,
  input  logic              mac_0_rx_sop,
  input  logic              mac_0_rx_eop,
  input  logic              mac_0_rx_valid,
  input  logic              mac_0_rx_error,
  output logic [DATA_W-1:0] mac_0_tx_data,
  output logic              mac_0_tx_sop,
  output logic              mac_0_tx_eop,
  output logic              mac_0_tx_valid,
  output logic              mac_0_tx_error,
  output logic              mac_0_tx_skip_crc,
  input  logic              mac_0_tx_ready,
  output logic [CNT_W-1:0]  fwd_pkt_cnt,
  output logic [CNT_W-1:0]  drop_pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, STORE, DISCARD} rx_state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  rx_state_t         state_q, state_d;
  logic [PW-1:0]     wr_ptr, wr_base, rd_ptr;
  logic [PW-1:0]     wr_ptr_d, wr_base_d, cur_ptr;
  logic [PW-1:0]     pkt_avail;
  logic              wr_en, commit, start, full;
  logic [1:0]        drop_n;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [DATA_W+1:0] rd_word_p0;
  logic [DATA_W-1:0] data_p1;
  logic              sop_p1, eop_p1, vld_p1;
  logic              load, xfer_eop;

  // A sop arriving mid-packet restarts the write at the committed base.
  assign cur_ptr = (state_q == STORE && mac_0_rx_sop) ? wr_base : wr_ptr;
  assign full    = ((cur_ptr - rd_ptr) == PW'(DEPTH));

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr;
    wr_base_d = wr_base;
    wr_en     = 1'b0;
    commit    = 1'b0;
    start     = 1'b0;
    drop_n    = 2'd0;
    if (mac_0_rx_valid) begin
      case (state_q)
        IDLE: start = mac_0_rx_sop;
        STORE: begin
          if (mac_0_rx_sop) begin
            drop_n   = 2'd1;
            wr_ptr_d = wr_base;
            start    = 1'b1;
          end else if (full) begin
            wr_ptr_d = wr_base;
            if (mac_0_rx_eop) begin
              drop_n  = 2'd1;
              state_d = IDLE;
            end else begin
              state_d = DISCARD;
            end
          end else begin
            wr_en = 1'b1;
            if (mac_0_rx_eop) begin
              state_d = IDLE;
              if (mac_0_rx_error) begin
                wr_ptr_d = wr_base;
                drop_n   = 2'd1;
              end else begin
                wr_ptr_d  = wr_ptr + PW'(1);
                wr_base_d = wr_ptr + PW'(1);
                commit    = 1'b1;
              end
            end else begin
              wr_ptr_d = wr_ptr + PW'(1);
            end
          end
        end
        DISCARD: begin
          if (mac_0_rx_sop) begin
            drop_n = 2'd1;
            start  = 1'b1;
          end else if (mac_0_rx_eop) begin
            drop_n  = 2'd1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        if (full) begin
          if (mac_0_rx_eop) begin
            drop_n  = drop_n + 2'd1;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else begin
          wr_en = 1'b1;
          if (mac_0_rx_eop) begin
            state_d = IDLE;
            if (mac_0_rx_error) begin
              drop_n = drop_n + 2'd1;
            end else begin
              wr_ptr_d  = cur_ptr + PW'(1);
              wr_base_d = cur_ptr + PW'(1);
              commit    = 1'b1;
            end
          end else begin
            wr_ptr_d = cur_ptr + PW'(1);
            state_d  = STORE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cur_ptr[AW-1:0]] <= {mac_0_rx_sop, mac_0_rx_eop, mac_0_rx_data};
  end

  // Read side stops at wr_base, so only committed words ever reach TX.
  assign rd_word_p0 = mem[rd_ptr[AW-1:0]];
  assign load       = (!vld_p1 || mac_0_tx_ready) && (rd_ptr != wr_base) && (pkt_avail != '0);
  assign xfer_eop   = vld_p1 && mac_0_tx_ready && eop_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      wr_base      <= '0;
      rd_ptr       <= '0;
      pkt_avail    <= '0;
      fwd_pkt_cnt  <= '0;
      drop_pkt_cnt <= '0;
      vld_p1       <= 1'b0;
      sop_p1       <= 1'b0;
      eop_p1       <= 1'b0;
      data_p1      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr       <= wr_ptr_d;
      wr_base      <= wr_base_d;
      drop_pkt_cnt <= sat_add(drop_pkt_cnt, drop_n);
      fwd_pkt_cnt  <= sat_add(fwd_pkt_cnt, {1'b0, xfer_eop});
      case ({commit, xfer_eop})
        2'b10:   pkt_avail <= pkt_avail + PW'(1);
        2'b01:   pkt_avail <= pkt_avail - PW'(1);
        default: pkt_avail <= pkt_avail;
      endcase
      // Output register stage
      if (load) begin
        data_p1 <= rd_word_p0[DATA_W-1:0];
        eop_p1  <= rd_word_p0[DATA_W];
        sop_p1  <= rd_word_p0[DATA_W+1];
        vld_p1  <= 1'b1;
        rd_ptr  <= rd_ptr + PW'(1);
      end else if (vld_p1 && mac_0_tx_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign mac_0_tx_data     = data_p1;
  assign mac_0_tx_sop      = sop_p1;
  assign mac_0_tx_eop      = eop_p1;
  assign mac_0_tx_valid    = vld_p1;
  assign mac_0_tx_error    = 1'b0;
  assign mac_0_tx_skip_crc = (SKIP_CRC != 0);

endmodule
